wb_gpio_slave: RTL
==================

WB_GPIO_SLAVE -- requirements
Module: wb_gpio_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address; decode compares wbs_adr_i[31:8] to BASE_ADDR[31:8].
REQ-002 SHALL have port wb_clk_i  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port wb_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each  Wishbone classic strobe, cycle, write-enable.
REQ-005 SHALL have ports wbs_sel_i input 4 byte enables; wbs_adr_i input 32 address; wbs_dat_i input 32 write data.
REQ-006 SHALL have ports wbs_ack_o output 1 acknowledge; wbs_dat_o output 32 read data.
REQ-007 SHALL have port io_active  input  1  block enable; low forces pads safe.
REQ-008 SHALL have ports io_in input 32; io_out output 32; io_oeb output 32 (1 = pad is input).
REQ-009 SHALL have port irq  output  1  level interrupt; present only with WB_GPIO_SLAVE_IRQ_EN.

Function
REQ-010 SHALL map word registers at wbs_adr_i[7:2]: 0 OUT (RW), 1 OEB (RW), 2 IN (RO), 3 EDGE_STS (W1C), 4 EDGE_MASK (RW).
REQ-011 SHALL detect a request when wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & base match; ack asserts the next cycle, exactly one cycle wide.
REQ-012 SHALL perform register write in the ack cycle; byte lane n updated only when wbs_sel_i[n]=1.
REQ-013 SHALL register wbs_dat_o in the ack cycle; wbs_dat_o = 0 outside ack cycles.
REQ-014 SHALL ack unmapped offsets and base-mismatched requests never; unmapped in-base offsets ack with read data 0, writes ignored.
REQ-015 SHALL ignore writes to IN; IN reads return io_in after a 2-flop synchronizer (2-cycle latency).
REQ-016 SHALL drive io_out = OUT and io_oeb = OEB when io_active=1; io_out = 0 and io_oeb = all-ones when io_active=0, registers unchanged.
REQ-017 SHALL keep Wishbone accesses functional regardless of io_active.
REQ-018 SHALL back-to-back: a stb held high after ack is re-serviced starting the cycle after ack deasserts (2-cycle minimum per transfer).

Reset
REQ-019 SHALL on wb_rst_n=0 asynchronously clear: OUT=0, OEB=32'hFFFF_FFFF, EDGE_STS=0, EDGE_MASK=0, synchronizer flops=0, wbs_ack_o=0, wbs_dat_o=0, irq=0.
REQ-020 SHALL abort any pending access on reset; no ack issued for a request accepted before reset.
REQ-021 SHALL release reset on the first wb_clk_i edge after wb_rst_n rises; no spurious edge status from synchronizer reset values.

Configuration
REQ-022 SHALL, with macro WB_GPIO_SLAVE_IRQ_EN defined, set EDGE_STS[n] on a synchronized rising edge of io_in[n] (set 3 cycles after pad change) and drive irq = |(EDGE_STS & EDGE_MASK), registered.
REQ-023 SHALL, with WB_GPIO_SLAVE_IRQ_EN defined, make edge-set win over simultaneous W1C clear of the same bit.
REQ-024 SHALL, without WB_GPIO_SLAVE_IRQ_EN, omit port irq, edge logic and EDGE_STS/EDGE_MASK; offsets 3 and 4 behave as unmapped (read 0).

Verification
REQ-025 SHALL test reset defaults: deassert reset, read OEB -> 32'hFFFF_FFFF, OUT -> 0, io_oeb all-ones.
REQ-026 SHALL test byte write: write OUT=32'hA5A5_A5A5 sel=4'b0101 after OUT=0 -> OUT reads 32'h00A5_00A5, io_out matches with io_active=1.
REQ-027 SHALL test io_active gating: OUT=32'hFFFF_FFFF, OEB=0, io_active=0 -> io_out=0, io_oeb=all-ones; io_active=1 -> io_out=all-ones, io_oeb=0.
REQ-028 SHALL test input latency: io_in 0->32'h1234_5678 -> IN read returns new value from the 2nd clock after change, old value before.
REQ-029 SHALL test IRQ (IRQ_EN): MASK=1, io_in[0] rises -> EDGE_STS=1, irq=1; W1C 1 on same cycle as new edge -> bit stays 1; later W1C -> irq=0.
REQ-030 SHALL test decode: access at BASE_ADDR+32'h100 -> no ack within 8 cycles; access at offset 0x40 -> ack, read 0.

Source files
------------

// File: rtl/wb_gpio_slave.sv
// -----------------------------------------------------------------------------
// wb_gpio_slave
//
// Wishbone classic slave exposing a 32-bit general purpose I/O block.
//
// Register map (word offsets at wbs_adr_i[7:2]):
//    0  OUT        RW   pad output values
//    1  OEB        RW   pad output-enable-bar (1 = pad is input)
//    2  IN         RO   io_in after a 2-flop synchronizer
//    3  EDGE_STS   W1C  latched rising edges of IN   (IRQ build only)
//    4  EDGE_MASK  RW   interrupt enables per bit    (IRQ build only)
// Other offsets inside the 256-byte window ack with read data 0.
// Requests outside the window are never acknowledged.
//
// Optional feature: define WB_GPIO_SLAVE_IRQ_EN to add the edge detector,
// EDGE_STS/EDGE_MASK and the irq output. Without it, offsets 3 and 4 read 0.
//
// Ports:
//    wb_clk_i       clock, all state on rising edge
//    wb_rst_n       asynchronous active-low reset
//    wbs_stb_i/cyc_i/we_i/sel_i/adr_i/dat_i   Wishbone request
//    wbs_ack_o/dat_o                          Wishbone response
//    io_active      block enable; low forces pads to a safe state
//    io_in          pad inputs
//    io_out         pad outputs
//    io_oeb         pad output-enable-bar
//    irq            level interrupt (WB_GPIO_SLAVE_IRQ_EN only)
// -----------------------------------------------------------------------------
module wb_gpio_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        io_active,
    input  logic [31:0] io_in,
    output logic [31:0] io_out,
    output logic [31:0] io_oeb
`ifdef WB_GPIO_SLAVE_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [5:0] IDX_OUT  = 6'd0;
    localparam logic [5:0] IDX_OEB  = 6'd1;
    localparam logic [5:0] IDX_IN   = 6'd2;
    localparam logic [5:0] IDX_STS  = 6'd3;
    localparam logic [5:0] IDX_MASK = 6'd4;

    logic [31:0] out_reg;
    logic [31:0] oeb_reg;
    logic [31:0] sync1;
    logic [31:0] sync2;
    logic [31:0] rdata;
    logic [31:0] lane_mask;
    logic [5:0]  reg_idx;
    logic        base_match;
    logic        req;
    logic        wr;
    logic        unused_adr;

    // Byte address bits are ignored; words only.
    assign unused_adr = ^wbs_adr_i[1:0];

    // A new request is only recognised while ack is low, which gives every
    // transfer a minimum of two cycles and lets a held strobe be re-serviced.
    assign base_match = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req        = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & base_match;
    assign wr         = req & wbs_we_i;
    assign reg_idx    = wbs_adr_i[7:2];
    assign lane_mask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                         {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    // Pads fall back to all-inputs, driving zero, when the block is disabled.
    // The registers themselves keep their contents.
    assign io_out = io_active ? out_reg : 32'h0000_0000;
    assign io_oeb = io_active ? oeb_reg : 32'hFFFF_FFFF;

`ifdef WB_GPIO_SLAVE_IRQ_EN
    logic [31:0] sync3;
    logic [31:0] edge_sts;
    logic [31:0] edge_mask;
    logic [2:0]  prime;
    logic [31:0] rise;
    logic [31:0] sts_clr;

    // Edges are ignored until the synchronizer and the delayed copy hold real
    // pad samples, so reset zeros cannot look like a rising edge.
    assign rise    = prime[2] ? (sync2 & ~sync3) : 32'h0000_0000;
    assign sts_clr = (wr && reg_idx == IDX_STS) ? (wbs_dat_i & lane_mask) : 32'h0000_0000;

    // Edge status: set terms are ORed in after the W1C clear, so a new edge
    // wins over a clear of the same bit in the same cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sync3     <= '0;
            prime     <= '0;
            edge_sts  <= '0;
            edge_mask <= '0;
            irq       <= 1'b0;
        end else begin
            sync3    <= sync2;
            prime    <= {prime[1:0], 1'b1};
            edge_sts <= (edge_sts & ~sts_clr) | rise;
            if (wr && reg_idx == IDX_MASK)
                edge_mask <= (edge_mask & ~lane_mask) | (wbs_dat_i & lane_mask);
            irq <= |(edge_sts & edge_mask);
        end
    end
`endif

    // Read data selection for the addressed word.
    always_comb begin
        rdata = 32'h0000_0000;
        case (reg_idx)
            IDX_OUT:  rdata = out_reg;
            IDX_OEB:  rdata = oeb_reg;
            IDX_IN:   rdata = sync2;
`ifdef WB_GPIO_SLAVE_IRQ_EN
            IDX_STS:  rdata = edge_sts;
            IDX_MASK: rdata = edge_mask;
`endif
            default:  rdata = 32'h0000_0000;
        endcase
    end

    // Two-flop synchronizer for the pad inputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= io_in;
            sync2 <= sync1;
        end
    end

    // OUT and OEB with per-byte write enables; written on the same edge that
    // raises ack, so the new value is visible during the ack cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            out_reg <= 32'h0000_0000;
            oeb_reg <= 32'hFFFF_FFFF;
        end else begin
            if (wr && reg_idx == IDX_OUT)
                out_reg <= (out_reg & ~lane_mask) | (wbs_dat_i & lane_mask);
            if (wr && reg_idx == IDX_OEB)
                oeb_reg <= (oeb_reg & ~lane_mask) | (wbs_dat_i & lane_mask);
        end
    end

    // Response: one-cycle ack, read data valid only while ack is high.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0000_0000;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : 32'h0000_0000;
        end
    end

endmodule
